// File: rtl/sram_bist_pkg.sv
// Shared types and the March C- element table for the SRAM BIST.
package sram_bist_pkg;

   // Controller states.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } bist_state_t;

   // Index of the final march element (ascending r0).
   localparam logic [2:0] ELEM_LAST = 3'd5;

   // One march element: address order plus the read and write halves.
   typedef struct packed {
      logic down;        // 1 = descending address order
      logic has_read;    // element starts each address with a read
      logic read_ones;   // expected read pattern is all ones
      logic has_write;   // element writes each address
      logic write_ones;  // written pattern is all ones
   } march_elem_t;

   // Address order of an element; element 0 runs ascending.
   function automatic logic march_dir(input logic [2:0] elem);
      return (elem == 3'd3) || (elem == 3'd4);
   endfunction

   // March C-: w0; up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0).
   function automatic march_elem_t march_table(input logic [2:0] elem);
      march_elem_t e;
      e = '0;
      e.down = march_dir(elem);
      case (elem)
         3'd0: begin
            e.has_write = 1'b1;
         end
         3'd1: begin
            e.has_read   = 1'b1;
            e.has_write  = 1'b1;
            e.write_ones = 1'b1;
         end
         3'd2: begin
            e.has_read  = 1'b1;
            e.read_ones = 1'b1;
            e.has_write = 1'b1;
         end
         3'd3: begin
            e.has_read   = 1'b1;
            e.has_write  = 1'b1;
            e.write_ones = 1'b1;
         end
         3'd4: begin
            e.has_read  = 1'b1;
            e.read_ones = 1'b1;
            e.has_write = 1'b1;
         end
         3'd5: begin
            e.has_read = 1'b1;
         end
         default: begin
            e = '0;
         end
      endcase
      return e;
   endfunction

endpackage

// File: rtl/sram_march_bist_if.sv
// Pin bundle between the BIST initiator (master) and the single-port array (slave).
interface sram_march_bist_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_din;
   logic [DATA_WIDTH-1:0] mem_dout;

   modport master (
      output mem_we,
      output mem_addr,
      output mem_din,
      input  mem_dout
   );

   modport slave (
      input  mem_we,
      input  mem_addr,
      input  mem_din,
      output mem_dout
   );

endinterface

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter for the march sequence: loads either end of the
// array, steps in the current element's direction and flags the last address.
module sram_bist_addr_gen #(
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,       // jump to the first address of an element
   input  logic                  load_down,  // order of the element being loaded
   input  logic                  step,       // advance one address
   input  logic                  down,       // order of the element in progress
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  last
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   // Address register: load has priority over step.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
      end else if (load) begin
         addr <= load_down ? ADDR_TOP : '0;
      end else if (step) begin
         addr <= down ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
      end
   end

   assign last = down ? (addr == '0) : (addr == ADDR_TOP);

endmodule

// File: rtl/sram_march_bist.sv
// March C- built-in self-test initiator for a single-port SRAM with
// registered reads. Reports the first failing address and march element.
module sram_march_bist
   import sram_bist_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [2:0]            fail_elem,
   sram_march_bist_if.master     bus
);

   bist_state_t           state;
   logic [2:0]            elem;       // current march element
   logic                  phase_wr;   // write half of a read/write element
   march_elem_t           ent;

   logic                  rd_cycle;
   logic                  wr_cycle;
   logic                  addr_done;  // last access for the current address
   logic                  start_accept;
   logic                  mismatch;

   logic                  ag_load;
   logic                  ag_load_down;
   logic                  ag_step;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  addr_last;

   // Check record for the read issued in the previous cycle.
   logic                  chk_pending;
   logic [DATA_WIDTH-1:0] chk_exp;
   logic [ADDR_WIDTH-1:0] chk_addr;
   logic [2:0]            chk_elem;

   // Access decode and address-counter control from registered state only.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      ent          = march_table(elem);
      rd_cycle     = 1'b0;
      wr_cycle     = 1'b0;
      addr_done    = 1'b0;
      if (state == ST_RUN) begin
         rd_cycle  = ent.has_read && !phase_wr;
         wr_cycle  = ent.has_write && (phase_wr || !ent.has_read);
         addr_done = !(ent.has_read && ent.has_write) || phase_wr;
      end
      start_accept = start && ((state == ST_IDLE) || (state == ST_DONE));
      ag_load      = start_accept || (addr_done && addr_last && (elem != ELEM_LAST));
      ag_load_down = start_accept ? 1'b0 : march_dir(elem + 3'd1);
      ag_step      = addr_done && !addr_last;
   end

   // Read data returns one cycle after the read; compare it against the record.
   assign mismatch = chk_pending && (bus.mem_dout != chk_exp);

   // Array pins: idle (all zero) outside RUN.
   assign bus.mem_we   = wr_cycle;
   assign bus.mem_addr = (state == ST_RUN) ? addr : '0;
   assign bus.mem_din  = wr_cycle ? {DATA_WIDTH{ent.write_ones}} : '0;

   sram_bist_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (ag_load),
      .load_down (ag_load_down),
      .step      (ag_step),
      .down      (ent.down),
      .addr      (addr),
      .last      (addr_last)
   );

   // Register a check record for every read; drop it once a mismatch ends the test.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_pending <= 1'b0;
         chk_exp     <= '0;
         chk_addr    <= '0;
         chk_elem    <= '0;
      end else begin
         chk_pending <= rd_cycle && !mismatch;
         if (rd_cycle) begin
            chk_exp  <= {DATA_WIDTH{ent.read_ones}};
            chk_addr <= addr;
            chk_elem <= elem;
         end
      end
   end

   // Controller FSM with registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         elem      <= '0;
         phase_wr  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_elem <= '0;
      end else if (mismatch && ((state == ST_RUN) || (state == ST_DRAIN))) begin
         // First failure wins: capture it and stop.
         state     <= ST_DONE;
         busy      <= 1'b0;
         done      <= 1'b1;
         fail      <= 1'b1;
         fail_addr <= chk_addr;
         fail_elem <= chk_elem;
         phase_wr  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_accept) begin
                  state     <= ST_RUN;
                  elem      <= '0;
                  phase_wr  <= 1'b0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  fail      <= 1'b0;
                  fail_addr <= '0;
                  fail_elem <= '0;
               end
            end
            ST_RUN: begin
               if (addr_done) begin
                  phase_wr <= 1'b0;
                  if (addr_last) begin
                     if (elem == ELEM_LAST) begin
                        state <= ST_DRAIN;
                     end else begin
                        elem <= elem + 3'd1;
                     end
                  end
               end else begin
                  phase_wr <= 1'b1;
               end
            end
            ST_DRAIN: begin
               // Final compare of the last element-5 read happened this cycle.
               state <= ST_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_march_bist.sv
// Self-checking bench for sram_march_bist: behavioural SRAM with stuck-at
// fault injection and an element-by-element March C- reference model.
module tb_sram_march_bist;

   localparam int DW         = 8;
   localparam int AW         = 4;
   localparam int DEPTH      = 16;
   localparam int RUN_CYCLES = 10 * DEPTH;
   localparam int RUN_LIMIT  = RUN_CYCLES + 20;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          busy;
   logic          done;
   logic          fail;
   logic [AW-1:0] fail_addr;
   logic [2:0]    fail_elem;

   int tests_run    = 0;
   int tests_failed = 0;

   sram_march_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   sram_march_bist #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .fail      (fail),
      .fail_addr (fail_addr),
      .fail_elem (fail_elem),
      .bus       (bus.master)
   );

   always #5 clk = ~clk;

   // Behavioural array with one faulty word.
   logic [DW-1:0] mem_arr [DEPTH];
   logic [DW-1:0] sa0_mask = '0;
   logic [DW-1:0] sa1_mask = '0;
   int            f_addr   = 0;

   function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] v);
      return (a == f_addr) ? ((v & ~sa0_mask) | sa1_mask) : v;
   endfunction

   always @(posedge clk) begin
      if (bus.mem_we) mem_arr[bus.mem_addr] <= faulty(int'(bus.mem_addr), bus.mem_din);
      bus.mem_dout <= faulty(int'(bus.mem_addr), mem_arr[bus.mem_addr]);
   end

   // March C- as written in the algorithm: order, read pattern, write pattern (-1 = none).
   int el_down [6] = '{0, 0, 0, 1, 1, 0};
   int el_rd   [6] = '{-1, 0, 1, 0, 1, 0};
   int el_wr   [6] = '{0, 1, 0, 1, 0, -1};

   // Bus trace and entry snapshot captured by run_bist.
   logic          tr_we   [RUN_CYCLES+1];
   logic [AW-1:0] tr_addr [RUN_CYCLES+1];
   logic [DW-1:0] tr_din  [RUN_CYCLES+1];
   logic [9:0]    entry_vec;

   // Reference: walk the march over a model array; predict outcome and done edge.
   task automatic model_run(output bit m_fail, output int m_elem, output int m_addr,
                            output int m_done_edge);
      logic [DW-1:0] m [DEPTH];
      int k;
      k = 0;
      m_fail = 1'b0; m_elem = 0; m_addr = 0; m_done_edge = 0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < DEPTH; i++) begin
            int a;
            logic [DW-1:0] pat;
            a = (el_down[e] != 0) ? DEPTH - 1 - i : i;
            if (!m_fail && el_rd[e] >= 0) begin
               pat = (el_rd[e] != 0) ? {DW{1'b1}} : {DW{1'b0}};
               if (m[a] !== pat) begin
                  m_fail = 1'b1; m_elem = e; m_addr = a; m_done_edge = k + 2;
               end
               k++;
            end
            if (!m_fail && el_wr[e] >= 0) begin
               pat  = (el_wr[e] != 0) ? {DW{1'b1}} : {DW{1'b0}};
               m[a] = faulty(a, pat);
               k++;
            end
         end
      end
      if (!m_fail) m_done_edge = k + 1;
   endtask

   // Start a run and follow it until done (bounded); n counts edges after E0.
   task automatic run_bist(input bit hold_start, output int done_edge, output int busy_cnt);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      entry_vec = {busy, done, fail, fail_addr, fail_elem};
      done_edge = 0;
      busy_cnt  = 0;
      while (!done && done_edge < RUN_LIMIT) begin
         if (busy) busy_cnt++;
         if (done_edge <= RUN_CYCLES) begin
            tr_we[done_edge]   = bus.mem_we;
            tr_addr[done_edge] = bus.mem_addr;
            tr_din[done_edge]  = bus.mem_din;
         end
         @(negedge clk);
         done_edge++;
      end
   endtask

   task automatic test_reset;
      logic [22:0] obs;
      #2;
      obs = {busy, done, fail, fail_addr, fail_elem, bus.mem_we, bus.mem_addr, bus.mem_din};
      tests_run++;
      if (obs !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h, expected 0", obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      obs = {busy, done, fail, fail_addr, fail_elem, bus.mem_we, bus.mem_addr, bus.mem_din};
      tests_run++;
      if (obs !== '0) begin
         tests_failed++;
         $display("FAIL idle_after_reset: got %h, expected 0", obs);
      end
   endtask

   task automatic test_pass_trace;
      int  de, bc, n;
      bit  m_fail;
      int  m_elem, m_addr, m_de;
      int  zeros_bad;
      sa0_mask = '0; sa1_mask = '0;
      model_run(m_fail, m_elem, m_addr, m_de);
      run_bist(1'b0, de, bc);
      tests_run++;
      if (de !== RUN_CYCLES + 1 || de !== m_de) begin
         tests_failed++;
         $display("FAIL pass_latency: done after %0d edges, expected %0d", de, RUN_CYCLES + 1);
      end
      tests_run++;
      if (bc !== RUN_CYCLES + 1) begin
         tests_failed++;
         $display("FAIL pass_busy_cycles: got %0d, expected %0d", bc, RUN_CYCLES + 1);
      end
      tests_run++;
      if ({busy, fail, fail_addr, fail_elem} !== '0) begin
         tests_failed++;
         $display("FAIL pass_status: busy=%b fail=%b addr=%0d elem=%0d, expected all 0",
                  busy, fail, fail_addr, fail_elem);
      end
      zeros_bad = 0;
      for (int a = 0; a < DEPTH; a++) if (mem_arr[a] !== '0) zeros_bad++;
      tests_run++;
      if (zeros_bad != 0) begin
         tests_failed++;
         $display("FAIL pass_array_zero: %0d nonzero words, expected 0", zeros_bad);
      end
      // Bus trace, one comparison per element.
      n = 0;
      for (int e = 0; e < 6; e++) begin
         bit bad;
         int bad_n;
         logic [AW-1:0] bad_addr;
         bad = 1'b0; bad_n = 0; bad_addr = '0;
         for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] ea;
            ea = AW'((el_down[e] != 0) ? DEPTH - 1 - i : i);
            for (int op = 0; op < 2; op++) begin
               bit active, is_wr;
               logic [DW-1:0] ed;
               is_wr  = (op == 1);
               active = is_wr ? (el_wr[e] >= 0) : (el_rd[e] >= 0);
               ed     = (is_wr && el_wr[e] == 1) ? {DW{1'b1}} : {DW{1'b0}};
               if (active) begin
                  if (!bad && (tr_we[n] !== is_wr || tr_addr[n] !== ea ||
                               (is_wr && tr_din[n] !== ed))) begin
                     bad = 1'b1; bad_n = n; bad_addr = ea;
                  end
                  n++;
               end
            end
         end
         tests_run++;
         if (bad) begin
            tests_failed++;
            $display("FAIL trace_elem%0d cycle %0d: got we=%b addr=%0d din=%h, expected addr=%0d",
                     e, bad_n, tr_we[bad_n], tr_addr[bad_n], tr_din[bad_n], bad_addr);
         end
      end
      tests_run++;
      if ({tr_we[RUN_CYCLES], tr_addr[RUN_CYCLES], tr_din[RUN_CYCLES]} !== '0) begin
         tests_failed++;
         $display("FAIL drain_bus_idle: got we=%b addr=%0d din=%h, expected 0",
                  tr_we[RUN_CYCLES], tr_addr[RUN_CYCLES], tr_din[RUN_CYCLES]);
      end
   endtask

   task automatic test_stuck_fault(input string name, input int fa, input logic [DW-1:0] s0,
                                   input logic [DW-1:0] s1, input int exp_elem);
      int  de, bc;
      bit  m_fail;
      int  m_elem, m_addr, m_de;
      f_addr = fa; sa0_mask = s0; sa1_mask = s1;
      model_run(m_fail, m_elem, m_addr, m_de);
      run_bist(1'b0, de, bc);
      tests_run++;
      if (done !== 1'b1 || fail !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_flags: done=%b fail=%b busy=%b, expected 1 1 0", name, done, fail, busy);
      end
      tests_run++;
      if (int'(fail_elem) != exp_elem || int'(fail_addr) != fa) begin
         tests_failed++;
         $display("FAIL %s_where: elem=%0d addr=%0d, expected elem=%0d addr=%0d",
                  name, fail_elem, fail_addr, exp_elem, fa);
      end
      tests_run++;
      if (de != m_de) begin
         tests_failed++;
         $display("FAIL %s_latency: done after %0d edges, expected %0d", name, de, m_de);
      end
   endtask

   task automatic test_restart_after_fail;
      int de, bc;
      sa0_mask = '0; sa1_mask = '0;
      run_bist(1'b0, de, bc);
      tests_run++;
      if (entry_vec !== {1'b1, 9'b0}) begin
         tests_failed++;
         $display("FAIL restart_entry: {busy,done,fail,addr,elem}=%b, expected %b",
                  entry_vec, {1'b1, 9'b0});
      end
      tests_run++;
      if (de != RUN_CYCLES + 1 || fail !== 1'b0) begin
         tests_failed++;
         $display("FAIL restart_run: done after %0d edges fail=%b, expected %0d fail=0",
                  de, fail, RUN_CYCLES + 1);
      end
   endtask

   task automatic test_random_faults;
      for (int it = 0; it < 8; it++) begin
         int kind, bitn, de, bc;
         bit m_fail;
         int m_elem, m_addr, m_de;
         logic [DW-1:0] one;
         one  = 1;
         kind = int'($urandom_range(2, 0));
         bitn = int'($urandom_range(DW - 1, 0));
         f_addr   = int'($urandom_range(DEPTH - 1, 0));
         sa0_mask = (kind == 1) ? (one << bitn) : '0;
         sa1_mask = (kind == 2) ? (one << bitn) : '0;
         model_run(m_fail, m_elem, m_addr, m_de);
         run_bist(1'b0, de, bc);
         tests_run++;
         if (fail !== m_fail || int'(fail_elem) != m_elem || int'(fail_addr) != m_addr ||
             de != m_de) begin
            tests_failed++;
            $display("FAIL random_fault%0d (kind %0d addr %0d bit %0d): fail=%b elem=%0d addr=%0d edges=%0d, expected fail=%b elem=%0d addr=%0d edges=%0d",
                     it, kind, f_addr, bitn, fail, fail_elem, fail_addr, de,
                     m_fail, m_elem, m_addr, m_de);
         end
      end
   endtask

   task automatic test_reset_mid_run;
      int de, bc;
      logic [22:0] obs;
      sa0_mask = '0; sa1_mask = '0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (50) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      obs = {busy, done, fail, fail_addr, fail_elem, bus.mem_we, bus.mem_addr, bus.mem_din};
      tests_run++;
      if (obs !== '0) begin
         tests_failed++;
         $display("FAIL midrun_reset_outputs: got %h, expected 0", obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_bist(1'b0, de, bc);
      tests_run++;
      if (de != RUN_CYCLES + 1 || bc != RUN_CYCLES + 1 || fail !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrun_rerun: edges=%0d busy=%0d fail=%b, expected %0d %0d 0",
                  de, bc, fail, RUN_CYCLES + 1, RUN_CYCLES + 1);
      end
   endtask

   task automatic test_start_held;
      int de, bc;
      sa0_mask = '0; sa1_mask = '0;
      run_bist(1'b1, de, bc);
      start = 1'b0;
      tests_run++;
      if (de != RUN_CYCLES + 1 || bc != RUN_CYCLES + 1) begin
         tests_failed++;
         $display("FAIL held_start_run: edges=%0d busy=%0d, expected %0d %0d",
                  de, bc, RUN_CYCLES + 1, RUN_CYCLES + 1);
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b0 || fail !== 1'b0) begin
         tests_failed++;
         $display("FAIL held_start_single: done=%b busy=%b fail=%b, expected 1 0 0",
                  done, busy, fail);
      end
   endtask

   initial begin
      test_reset();
      test_pass_trace();
      test_stuck_fault("stuck_at0", 5, 8'h08, 8'h00, 2);
      test_restart_after_fail();
      test_stuck_fault("stuck_at1", 0, 8'h00, 8'h01, 1);
      test_random_faults();
      test_reset_mid_run();
      test_start_held();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

Built-in self-test initiator for the single-port `sram` array. It drives the array's `we`/`addr`/`din` pins and checks `dout` while running a March C- sequence over all `DEPTH` words. It reports pass/fail, and on failure the first failing address and march element. It sits between the array and the system-side memory mux; that mux grants the array pins to this block while `busy` is high.

## Interface
- `DATA_WIDTH`, default 8: array word width.
- `ADDR_WIDTH`, default 4: array address width.
- `DEPTH`, default 2**ADDR_WIDTH: number of words tested, 2 ≤ `DEPTH` ≤ 2**ADDR_WIDTH.
- `clk`  in  1: single clock, shared with the array.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: level, sampled on rising `clk`; acted on only in IDLE or DONE.
- `busy`  out  1: high in RUN and DRAIN.
- `done`  out  1: high in DONE.
- `fail`  out  1: valid while `done`=1; 1 means a mismatch was found.
- `fail_addr`  out  ADDR_WIDTH: address of the first mismatch; 0 if the test passed.
- `fail_elem`  out  3: march element index (0–5) of the first mismatch; 0 if the test passed.
- `mem_we`  out  1: to array `we`.
- `mem_addr`  out  ADDR_WIDTH: to array `addr`.
- `mem_din`  out  DATA_WIDTH: to array `din`.
- `mem_dout`  in  DATA_WIDTH: from array `dout`.

## Operation
- Array contract: reads are registered. `dout` after edge N equals `mem[addr]` sampled at edge N, which is the old data if `we` was also high at edge N.
- March C-, with P0 = all zeros and P1 = all ones:
  - element 0: any order, w0
  - element 1: ascending, r0 then w1
  - element 2: ascending, r1 then w0
  - element 3: descending, r0 then w1
  - element 4: descending, r1 then w0
  - element 5: ascending, r0
- Ascending runs 0..DEPTH-1; descending runs DEPTH-1..0. Element 0 is performed ascending.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN when `start`=1.
  - RUN → DRAIN after the last read of element 5.
  - RUN or DRAIN → DONE on the first mismatch.
  - DRAIN → DONE after one cycle.
  - DONE → RUN when `start`=1.
- Each read registers a check record: pending flag, expected pattern, address, element. In the following cycle `mem_dout` is compared against the expected pattern.
- In r/w elements the compare cycle is the same cycle as the write to that address. The write is still issued even if that compare fails.
- On a mismatch: capture `fail_addr` and `fail_elem`, set `fail`, and go to DONE. The test stops at the first failure.
- Restart from DONE clears `done`, `fail`, `fail_addr` and `fail_elem` on the same edge that enters RUN.
- `start` while in RUN or DRAIN is ignored.
- Outside RUN the memory bus is idle: `mem_we`=0, `mem_addr`=0, `mem_din`=0.
- Reset: state IDLE and every output 0, asynchronously. Reset during RUN abandons the test; the array contents are then undefined.

## Timing
- Memory outputs are decoded combinationally from the registered state and counters only, never from `mem_dout`.
- Edge E0 samples `start`=1 in IDLE. Immediately after E0, `busy`=1 and the bus shows element 0, addr 0, `mem_we`=1.
- Each access holds for one cycle. Cycles per element:
  - elements 0 and 5: `DEPTH` cycles each.
  - elements 1–4: 2·`DEPTH` cycles each, read cycle then write cycle per address.
- RUN lasts 10·`DEPTH` cycles, then one DRAIN cycle.
- On a pass, `done`=1 after edge E0+10·`DEPTH`+1 (E0+161 for `DEPTH`=16), and `busy` falls on the same edge.
- On a mismatch compared in cycle C, `done`=`fail`=1 after the edge that ends C, and `busy` falls on that edge.
- `done`, `fail`, `fail_addr` and `fail_elem` hold until restart or reset.

## Structure
- Shared package `sram_bist_pkg` holds:
  - the state enum;
  - `ELEM_LAST` = 5;
  - a march table function: element index → {direction, has_read, read_pattern_is_ones, has_write, write_pattern_is_ones}.
- Sub-module `sram_bist_addr_gen` is the up/down address counter. It loads 0 or DEPTH-1, steps on command, and flags the terminal address. The FSM and checker stay in the top level.

## Test plan
- **Fault-free array:** `DEPTH`=16, pulse `start` → `busy` for 161 cycles, then `done`=1, `fail`=0; the array holds all zeros afterwards.
- **Stuck-at-0:** bit 3 stuck at 0 at addr 5 → `done`, `fail`=1, `fail_elem`=2, `fail_addr`=5.
- **Stuck-at-1:** bit 0 stuck at 1 at addr 0 → `fail`=1, `fail_elem`=1, `fail_addr`=0. This is detected at the first read of element 1.
- **Bus trace for element 3:** addresses run 15 down to 0. Each address shows two cycles: `mem_we`=0, then `mem_we`=1 with `mem_din`=8'hFF.
- **Reset mid-run:** `rst_n` low at cycle 50 → all outputs 0 with no clock edge; after release, `start` → full 161-cycle pass.
- **Start handling:**
  - `start` held high through the whole run → exactly one run.
  - `start` in DONE after a failed run → `done`/`fail` cleared on the entering edge, new full run.
